// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle MULT/MULTU/DIV/DIVU controller.
// Borrows the shared 32-bit execute ALU one operation per cycle.
// Multiply uses shift-add; divide uses restoring shift-subtract.
// Signed operations are handled on magnitudes, with the sign fixed up at the end.
// HI/LO hold the result until the next accepted start.

package muldiv_pkg;
    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_OR  = 2'd3
    } aluop_t;
endpackage

module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [WORD_W-1:0] rs_val,
    input  logic [WORD_W-1:0] rt_val,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] hi,
    output logic [WORD_W-1:0] lo,
    output logic              alu_req,
    output aluop_t            alu_op,
    output logic [WORD_W-1:0] alu_a,
    output logic [WORD_W-1:0] alu_b,
    input  logic [WORD_W-1:0] alu_o
);

    localparam logic [WORD_W-1:0] W_ZERO = {WORD_W{1'b0}};
    localparam logic [WORD_W-1:0] W_ONES = {WORD_W{1'b1}};

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        NEG_A  = 3'd1,
        NEG_B  = 3'd2,
        ITER   = 3'd3,
        NEG_LO = 3'd4,
        NEG_HI = 3'd5,
        DONE   = 3'd6
    } state_t;

    // op[1]=1 selects divide, op[0]=1 selects unsigned.
    // hi_q/lo_q hold the working registers:
    //   multiply: acc_hi and multiplier/product-low
    //   divide:   remainder and dividend/quotient
    // opnd_q holds the multiplicand or the divisor.
    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [WORD_W-1:0] hi_q, hi_d;
    logic [WORD_W-1:0] lo_q, lo_d;
    logic [WORD_W-1:0] opnd_q, opnd_d;
    logic [4:0]        cnt_q, cnt_d;
    logic              sign_lo_q, sign_lo_d;
    logic              sign_hi_q, sign_hi_d;
    logic              lo_zero_q, lo_zero_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              is_div_s;
    logic              carry_s;
    logic              take_s;
    logic [WORD_W-1:0] s_low_s;

    assign is_div_s = op_q[1];
    // Low 32 bits of the 33-bit partial remainder {rem, quo[31]}.
    assign s_low_s  = {hi_q[WORD_W-2:0], lo_q[WORD_W-1]};
    // A subtraction is taken if the shifted-out remainder bit is set,
    // or if the low word alone still covers the divisor.
    assign take_s   = hi_q[WORD_W-1] | (s_low_s >= opnd_q);
    // Carry out of acc_hi + addend, recovered from the 32-bit ALU sum.
    assign carry_s  = (alu_o < hi_q);

    assign busy    = busy_q;
    assign done    = done_q;
    assign alu_req = busy_q;
    assign hi      = hi_q;
    assign lo      = lo_q;

    // Drive the borrowed ALU from registered state only; it idles at ADD 0+0.
    always_comb begin
        alu_op = ALU_ADD;
        alu_a  = W_ZERO;
        alu_b  = W_ZERO;
        case (state_q)
            NEG_A: begin
                alu_op = ALU_SUB;
                alu_b  = is_div_s ? lo_q : opnd_q;
            end
            NEG_B: begin
                alu_op = ALU_SUB;
                alu_b  = is_div_s ? opnd_q : lo_q;
            end
            ITER: begin
                if (is_div_s) begin
                    alu_op = ALU_SUB;
                    alu_a  = s_low_s;
                    alu_b  = opnd_q;
                end else begin
                    alu_op = ALU_ADD;
                    alu_a  = hi_q;
                    alu_b  = lo_q[0] ? opnd_q : W_ZERO;
                end
            end
            NEG_LO: begin
                alu_op = ALU_SUB;
                alu_b  = lo_q;
            end
            NEG_HI: begin
                if (is_div_s) begin
                    alu_op = ALU_SUB;
                    alu_b  = hi_q;
                end else begin
                    // Upper half of a 64-bit negate: ~hi plus the borrow from lo.
                    alu_op = ALU_ADD;
                    alu_a  = ~hi_q;
                    alu_b  = {{(WORD_W-1){1'b0}}, lo_zero_q};
                end
            end
            default: begin
                alu_op = ALU_ADD;
                alu_a  = W_ZERO;
                alu_b  = W_ZERO;
            end
        endcase
    end

    // Next-state and datapath update for every sequencer state.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        opnd_d    = opnd_q;
        cnt_d     = cnt_q;
        sign_lo_d = sign_lo_q;
        sign_hi_d = sign_hi_q;
        lo_zero_d = lo_zero_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    op_d      = op;
                    cnt_d     = 5'd0;
                    sign_lo_d = rs_val[WORD_W-1] ^ rt_val[WORD_W-1];
                    sign_hi_d = op[1] ? rs_val[WORD_W-1]
                                      : (rs_val[WORD_W-1] ^ rt_val[WORD_W-1]);
                    if (op[1] && (rt_val == W_ZERO)) begin
                        // Divide by zero: fixed result, the ALU is never touched.
                        hi_d    = rs_val;
                        lo_d    = W_ONES;
                        state_d = DONE;
                    end else begin
                        hi_d = W_ZERO;
                        if (op[1]) begin
                            lo_d   = rs_val;
                            opnd_d = rt_val;
                        end else begin
                            lo_d   = rt_val;
                            opnd_d = rs_val;
                        end
                        state_d = op[0] ? ITER : NEG_A;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            NEG_A: begin
                // rs lives in lo (divide) or opnd (multiply).
                if (is_div_s) begin
                    lo_d = lo_q[WORD_W-1] ? alu_o : lo_q;
                end else begin
                    opnd_d = opnd_q[WORD_W-1] ? alu_o : opnd_q;
                end
                state_d = NEG_B;
            end
            NEG_B: begin
                // rt lives in opnd (divide) or lo (multiply).
                if (is_div_s) begin
                    opnd_d = opnd_q[WORD_W-1] ? alu_o : opnd_q;
                end else begin
                    lo_d = lo_q[WORD_W-1] ? alu_o : lo_q;
                end
                cnt_d   = 5'd0;
                state_d = ITER;
            end
            ITER: begin
                if (is_div_s) begin
                    hi_d = take_s ? alu_o : s_low_s;
                    lo_d = {lo_q[WORD_W-2:0], take_s};
                end else begin
                    hi_d = {carry_s, alu_o[WORD_W-1:1]};
                    lo_d = {alu_o[0], lo_q[WORD_W-1:1]};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = op_q[0] ? DONE : NEG_LO;
                end else begin
                    state_d = ITER;
                end
            end
            NEG_LO: begin
                lo_zero_d = (lo_q == W_ZERO);
                if (sign_lo_q) begin
                    lo_d = alu_o;
                end else begin
                    lo_d = lo_q;
                end
                state_d = NEG_HI;
            end
            NEG_HI: begin
                if (sign_hi_q) begin
                    hi_d = alu_o;
                end else begin
                    hi_d = hi_q;
                end
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE) && (state_d != DONE);
        done_d = (state_d == DONE);
    end

    // State register with synchronous active-low reset; reset drops any operation in flight.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q   <= IDLE;
            op_q      <= 2'd0;
            hi_q      <= W_ZERO;
            lo_q      <= W_ZERO;
            opnd_q    <= W_ZERO;
            cnt_q     <= 5'd0;
            sign_lo_q <= 1'b0;
            sign_hi_q <= 1'b0;
            lo_zero_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            opnd_q    <= opnd_d;
            cnt_q     <= cnt_d;
            sign_lo_q <= sign_lo_d;
            sign_hi_q <= sign_hi_d;
            lo_zero_q <= lo_zero_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer with a behavioural ALU attached.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic        busy, done, alu_req;
    logic [31:0] hi, lo, alu_a, alu_b, alu_o;
    aluop_t      alu_op;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    muldiv_sequencer #(.WORD_W(32)) dut (
        .CLK(CLK), .nRST(nRST), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val),
        .busy(busy), .done(done), .hi(hi), .lo(lo),
        .alu_req(alu_req), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_o(alu_o)
    );

    // Behavioural model of the shared execute ALU.
    always_comb begin
        case (alu_op)
            ALU_ADD: alu_o = alu_a + alu_b;
            ALU_SUB: alu_o = alu_a - alu_b;
            ALU_AND: alu_o = alu_a & alu_b;
            ALU_OR:  alu_o = alu_a | alu_b;
            default: alu_o = 32'd0;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Launch one operation and check latency, busy/alu_req behaviour and the result.
    task automatic do_op(input string nm, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int lat,
                         input logic [31:0] eh, input logic [31:0] el);
        int n, busy_bad, req_bad, req_seen;
        n = 0; busy_bad = 0; req_bad = 0; req_seen = 0;
        @(negedge CLK);
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        @(posedge CLK);
        #1 start = 1'b0;
        while (n < 100) begin
            @(negedge CLK);
            n++;
            if (alu_req !== busy) req_bad++;
            if (done) break;
            if (!busy) busy_bad++;
            if (alu_req) req_seen++;
        end
        chk({nm, "_lat"}, 64'(n), 64'(lat));
        chk({nm, "_hi"}, {32'd0, hi}, {32'd0, eh});
        chk({nm, "_lo"}, {32'd0, lo}, {32'd0, el});
        chk({nm, "_busy_gap"}, 64'(busy_bad), 64'd0);
        chk({nm, "_req_eq_busy"}, 64'(req_bad), 64'd0);
        chk({nm, "_req_cycles"}, 64'(req_seen), 64'(lat - 1));
        chk({nm, "_busy_at_done"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, m, ndone, first;

        // Reset state.
        repeat (3) @(negedge CLK);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_req", {63'd0, alu_req}, 64'd0);
        chk("rst_hi", {32'd0, hi}, 64'd0);
        chk("rst_lo", {32'd0, lo}, 64'd0);
        chk("rst_alu_op", {62'd0, alu_op}, {62'd0, ALU_ADD});
        chk("rst_alu_ab", {alu_a, alu_b}, 64'd0);
        nRST = 1'b1;

        do_op("multu_ff", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'hFFFFFFFE, 32'h00000001);
        do_op("mult_m3x7", 2'b00, 32'hFFFFFFFD, 32'd7, 37, 32'hFFFFFFFF, 32'hFFFFFFEB);
        do_op("mult_0xm5", 2'b00, 32'd0, 32'hFFFFFFFB, 37, 32'd0, 32'd0);
        do_op("mult_m2xm3", 2'b00, 32'hFFFFFFFE, 32'hFFFFFFFD, 37, 32'd0, 32'd6);
        do_op("div_m7d2", 2'b10, 32'hFFFFFFF9, 32'd2, 37, 32'hFFFFFFFF, 32'hFFFFFFFD);
        do_op("divu_100d7", 2'b11, 32'd100, 32'd7, 33, 32'd2, 32'd14);
        do_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 37, 32'd0, 32'h80000000);
        do_op("divu_5d0", 2'b11, 32'd5, 32'd0, 1, 32'd5, 32'hFFFFFFFF);

        // A start pulse during ITER must be ignored.
        @(negedge CLK);
        start = 1'b1; op = 2'b01; rs_val = 32'd3; rt_val = 32'd5;
        @(posedge CLK);
        #1 start = 1'b0;
        ndone = 0; first = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge CLK);
            if (i == 5) begin
                start = 1'b1; op = 2'b11; rs_val = 32'd9; rt_val = 32'd0;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                ndone++;
                if (first == 0) first = i;
            end
        end
        chk("ign_ndone", 64'(ndone), 64'd1);
        chk("ign_lat", 64'(first), 64'd33);
        chk("ign_result", {hi, lo}, {32'd0, 32'd15});

        // Start held through DONE restarts immediately: 33-cycle spacing.
        @(negedge CLK);
        start = 1'b1; op = 2'b01; rs_val = 32'd2; rt_val = 32'd3;
        @(posedge CLK);
        #1 rs_val = 32'd4; rt_val = 32'd5;
        n = 0;
        while (n < 100) begin
            @(negedge CLK);
            n++;
            if (done) break;
        end
        chk("b2b_first_lat", 64'(n), 64'd33);
        chk("b2b_first_res", {hi, lo}, {32'd0, 32'd6});
        @(posedge CLK);
        #1 start = 1'b0;
        m = 0;
        while (m < 100) begin
            @(negedge CLK);
            m++;
            if (done) break;
        end
        chk("b2b_spacing", 64'(m), 64'd33);
        chk("b2b_second_res", {hi, lo}, {32'd0, 32'd20});

        // Reset at ITER count 10, with start asserted on the same edge.
        @(negedge CLK);
        start = 1'b1; op = 2'b01; rs_val = 32'h00012345; rt_val = 32'h00006789;
        @(posedge CLK);
        #1 start = 1'b0;
        repeat (11) @(negedge CLK);
        chk("pre_rst_busy", {63'd0, busy}, 64'd1);
        nRST = 1'b0; start = 1'b1; op = 2'b01;
        @(posedge CLK);
        #1 start = 1'b0; nRST = 1'b1;
        @(negedge CLK);
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_req", {63'd0, alu_req}, 64'd0);
        chk("mid_rst_hilo", {hi, lo}, 64'd0);
        ndone = 0;
        repeat (45) begin
            @(negedge CLK);
            if (done) ndone++;
        end
        chk("mid_rst_no_done", 64'(ndone), 64'd0);
        do_op("multu_6x7", 2'b01, 32'd6, 32'd7, 33, 32'd0, 32'd42);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
